alu_exec_stage: RTL and testbench

Execute stage of the RV32I pipeline: consumes the `alu_ops_t` control produced by the ALU decoder plus the two resolved source operands, computes the result, and holds it in a two-entry skid buffer toward memory/writeback. Valid/ready handshakes on both sides decouple decode from downstream stalls without a combinational ready path. A flush input discards in-flight results on branch redirect.

---
 rtl/riscv_pkg.sv | 39 +++
 rtl/alu_exec_stage_if.sv | 29 ++
 rtl/alu_exec_stage_alu_core.sv | 24 ++
 rtl/alu_exec_stage.sv | 86 ++++++++
 tb/tb_alu_exec_stage.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I types: ALU operation encoding, execute-stage buffer state and result entry.
// The result entry carries its zero flag so downstream branch logic needs no compare.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int RD_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6
  } alu_ops_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } ex_buf_state_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            zero;
    logic [RD_W-1:0] rd;
  } ex_result_t;

  function automatic ex_result_t make_result(input logic [XLEN-1:0] result,
                                             input logic [RD_W-1:0] rd);
    ex_result_t r;
    r.result = result;
    r.zero   = (result == '0);
    r.rd     = rd;
    return r;
  endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// Execute-stage handshake bundle: decode-side input, writeback-side output and flush.
// master drives instructions and out_ready; slave is the execute stage.
interface alu_exec_stage_if import riscv_pkg::*; #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  alu_ops_t        in_alu_ctrl;
  logic [XLEN-1:0] in_src_a;
  logic [XLEN-1:0] in_src_b;
  logic [RD_W-1:0] in_rd;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            out_zero;
  logic [RD_W-1:0] out_rd;

  modport master (
    output flush, in_valid, in_alu_ctrl, in_src_a, in_src_b, in_rd, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_rd
  );

  modport slave (
    input  flush, in_valid, in_alu_ctrl, in_src_a, in_src_b, in_rd, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_rd
  );
endinterface

// File: rtl/alu_exec_stage_alu_core.sv
// Combinational RV32I ALU datapath, zero latency, no flow control.
// Unknown encodings fall back to ADD so a decoder glitch never yields X.
module alu_core import riscv_pkg::*; (
  input  alu_ops_t        alu_ctrl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  always_comb begin
    result = a + b;
    case (alu_ctrl)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      default:  result = a + b;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// RV32I execute stage: ALU at the input, result visible the cycle after acceptance.
// Two-entry skid buffer; in_ready is registered and drops only once both entries hold data.
module alu_exec_stage import riscv_pkg::*; (
  input  logic            clk,
  input  logic            rst,
  alu_exec_stage_if.slave bus
);

  ex_buf_state_t state_q, state_d;
  ex_result_t    main_q, main_d;
  ex_result_t    skid_q, skid_d;
  ex_result_t    new_entry;
  logic          in_ready_q;
  logic [XLEN-1:0] alu_result;
  logic          in_xfer;
  logic          out_xfer;

  alu_core u_alu_core (
    .alu_ctrl (bus.in_alu_ctrl),
    .a        (bus.in_src_a),
    .b        (bus.in_src_b),
    .result   (alu_result)
  );

  assign new_entry = make_result(alu_result, bus.in_rd);

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = (state_q != EMPTY);
  assign bus.out_result = main_q.result;
  assign bus.out_zero   = main_q.zero;
  assign bus.out_rd     = main_q.rd;

  assign in_xfer  = bus.in_valid && in_ready_q;
  assign out_xfer = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    // Flush wins: the input seen this cycle is dropped, a concurrent output still completes.
    if (bus.flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_d  = new_entry;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (in_xfer && out_xfer) begin
            main_d = new_entry;
          end else if (in_xfer) begin
            skid_d  = new_entry;
            state_d = FULL;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != FULL);
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: ALU ops, skid ordering under stall, flush and async reset.
module tb_alu_exec_stage;
  import riscv_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  alu_exec_stage_if #(.XLEN(32), .RD_W(5)) bus ();

  alu_exec_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input alu_ops_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic v);
    bus.in_alu_ctrl = op;
    bus.in_src_a    = a;
    bus.in_src_b    = b;
    bus.in_rd       = rd;
    bus.in_valid    = v;
  endtask

  initial begin
    logic [3:0] bad_op;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive(ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0);

    #12;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_result", bus.out_result, 32'd0);
    chk("rst_out_zero", {31'd0, bus.out_zero}, 32'd0);
    chk("rst_out_rd", {27'd0, bus.out_rd}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    rst = 1'b0;

    // Back-to-back ops with out_ready high: one result per cycle.
    bus.out_ready = 1'b1;
    drive(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 5'd3, 1'b1);
    tick();
    chk("add_wrap_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("add_wrap_result", bus.out_result, 32'd0);
    chk("add_wrap_zero", {31'd0, bus.out_zero}, 32'd1);
    chk("add_wrap_rd", {27'd0, bus.out_rd}, 32'd3);

    drive(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 5'd4, 1'b1);
    tick();
    chk("slt_result", bus.out_result, 32'd1);
    chk("slt_zero", {31'd0, bus.out_zero}, 32'd0);

    drive(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1);
    tick();
    chk("sltu_result", bus.out_result, 32'd0);
    chk("sltu_zero", {31'd0, bus.out_zero}, 32'd1);

    drive(ALU_SUB, 32'd5, 32'd7, 5'd6, 1'b1);
    tick();
    chk("sub_result", bus.out_result, 32'hFFFF_FFFE);

    drive(ALU_XOR, 32'hF0F0_1234, 32'h0FF0_1234, 5'd7, 1'b1);
    tick();
    chk("xor_result", bus.out_result, 32'hFF00_0000);

    drive(ALU_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd8, 1'b1);
    tick();
    chk("and_result", bus.out_result, 32'h00F0_000F);

    drive(ALU_OR, 32'hF000_0001, 32'h0000_0F00, 5'd9, 1'b1);
    tick();
    chk("or_result", bus.out_result, 32'hF000_0F01);

    bad_op = 4'hF;
    drive(alu_ops_t'(bad_op), 32'd3, 32'd4, 5'd10, 1'b1);
    tick();
    chk("undef_op_result", bus.out_result, 32'd7);
    chk("undef_op_rd", {27'd0, bus.out_rd}, 32'd10);

    drive(ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0);
    tick();
    chk("drain_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("drain_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Downstream stall: two accepted, third held until space frees.
    bus.out_ready = 1'b0;
    drive(ALU_ADD, 32'd1, 32'd0, 5'd1, 1'b1);
    tick();
    chk("stall1_result", bus.out_result, 32'd1);
    chk("stall1_in_ready", {31'd0, bus.in_ready}, 32'd1);
    drive(ALU_ADD, 32'd2, 32'd0, 5'd2, 1'b1);
    tick();
    chk("stall2_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("stall2_result_held", bus.out_result, 32'd1);
    drive(ALU_ADD, 32'd3, 32'd0, 5'd3, 1'b1);
    tick();
    chk("stall3_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("stall3_result_held", bus.out_result, 32'd1);
    chk("stall3_rd_held", {27'd0, bus.out_rd}, 32'd1);
    bus.out_ready = 1'b1;
    tick();
    chk("order_2_result", bus.out_result, 32'd2);
    chk("order_2_rd", {27'd0, bus.out_rd}, 32'd2);
    chk("order_2_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    chk("order_3_result", bus.out_result, 32'd3);
    chk("order_3_valid", {31'd0, bus.out_valid}, 32'd1);
    drive(ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0);
    tick();
    chk("order_end_valid", {31'd0, bus.out_valid}, 32'd0);

    // Flush while FULL with a live input: everything is discarded.
    bus.out_ready = 1'b0;
    drive(ALU_ADD, 32'd10, 32'd0, 5'd11, 1'b1);
    tick();
    drive(ALU_ADD, 32'd11, 32'd0, 5'd12, 1'b1);
    tick();
    chk("flush_pre_in_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.flush = 1'b1;
    drive(ALU_ADD, 32'd99, 32'd0, 5'd13, 1'b1);
    tick();
    bus.flush = 1'b0;
    drive(ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0);
    chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b1;
    tick();
    chk("flush_no_ghost", {31'd0, bus.out_valid}, 32'd0);

    // Async reset while BUSY clears outputs with no clock edge.
    bus.out_ready = 1'b0;
    drive(ALU_ADD, 32'h20, 32'd0, 5'd7, 1'b1);
    tick();
    chk("pre_rst_result", bus.out_result, 32'h20);
    drive(ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("async_rst_result", bus.out_result, 32'd0);
    chk("async_rst_rd", {27'd0, bus.out_rd}, 32'd0);
    chk("async_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    rst = 1'b0;
    tick();
    chk("post_rst_valid", {31'd0, bus.out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
